// File: rtl/imm_encode.sv
// Immediate encoder: packs a signed immediate into instruction bits [31:7]
// for I/S/B/J formats behind a two-stage valid/ready pipeline, counting errors.
module imm_encode (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_imm,
    input  logic [1:0]  in_src,
    input  logic [24:0] in_base,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [24:0] out_field,
    output logic        out_err,
    input  logic        err_clr,
    output logic [7:0]  err_count
);
    localparam logic [1:0] SRC_I = 2'b00;
    localparam logic [1:0] SRC_S = 2'b01;
    localparam logic [1:0] SRC_B = 2'b10;
    localparam logic [1:0] SRC_J = 2'b11;

    logic [24:0] pack_field;
    logic        pack_err;
    logic        fits_12;
    logic        fits_13;
    logic        fits_21;

    logic        s1_valid;
    logic [24:0] s1_field;
    logic        s1_err;

    logic        in_fire;
    logic        out_fire;
    logic        s2_load;

    // An immediate fits n bits when everything above bit n-2 is a copy of the sign.
    assign fits_12 = (&in_imm[31:11]) | ~(|in_imm[31:11]);
    assign fits_13 = (&in_imm[31:12]) | ~(|in_imm[31:12]);
    assign fits_21 = (&in_imm[31:20]) | ~(|in_imm[31:20]);

    always_comb begin
        pack_field = in_base;
        pack_err   = 1'b0;
        case (in_src)
            SRC_I: begin
                pack_field[24:13] = in_imm[11:0];
                pack_err          = ~fits_12;
            end
            SRC_S: begin
                pack_field[24:18] = in_imm[11:5];
                pack_field[4:0]   = in_imm[4:0];
                pack_err          = ~fits_12;
            end
            SRC_B: begin
                pack_field[24]    = in_imm[12];
                pack_field[23:18] = in_imm[10:5];
                pack_field[4:1]   = in_imm[4:1];
                pack_field[0]     = in_imm[11];
                pack_err          = ~fits_13 | in_imm[0];
            end
            SRC_J: begin
                pack_field[24]    = in_imm[20];
                pack_field[23:14] = in_imm[10:1];
                pack_field[13]    = in_imm[11];
                pack_field[12:5]  = in_imm[19:12];
                pack_err          = ~fits_21 | in_imm[0];
            end
            default: begin
                pack_field = in_base;
                pack_err   = 1'b0;
            end
        endcase
    end

    assign s2_load  = ~out_valid | out_ready;
    assign in_ready = ~s1_valid | ~out_valid | out_ready;
    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_valid & out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_field <= '0;
            s1_err   <= 1'b0;
        end else if (in_fire) begin
            s1_valid <= 1'b1;
            s1_field <= pack_field;
            s1_err   <= pack_err;
        end else if (s2_load) begin
            s1_valid <= 1'b0;
        end
    end

    // Payload only moves with a real item so a drained stage keeps its last value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_field <= '0;
            out_err   <= 1'b0;
        end else if (s2_load) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_field <= s1_field;
                out_err   <= s1_err;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_count <= '0;
        end else if (err_clr) begin
            err_count <= '0;
        end else if (out_fire && out_err && (err_count != 8'hFF)) begin
            err_count <= err_count + 8'd1;
        end
    end

endmodule

// File: doc/imm_encode.md
IMM_ENCODE -- requirements
Module: imm_encode

Interface
REQ-001 clk  input  1  rising-edge clock for all state.
REQ-002 rst_n  input  1  asynchronous, active-low reset.
REQ-003 in_valid  input  1  request valid.
REQ-004 in_ready  output  1  block can accept a request this cycle.
REQ-005 in_imm  input  32  signed/byte-offset immediate to encode.
REQ-006 in_src  input  2  immediate type: 00 I, 01 S, 10 B, 11 J (same coding as the extend unit's ImmSrc).
REQ-007 in_base  input  25  instruction bits [31:7] supplying every bit not owned by the immediate.
REQ-008 out_valid  output  1  encoded result valid.
REQ-009 out_ready  input  1  consumer accepts result.
REQ-010 out_field  output  25  encoded instruction bits [31:7], decodable by the extend unit.
REQ-011 out_err  output  1  immediate not representable in the selected type.
REQ-012 err_clr  input  1  synchronous clear of err_count.
REQ-013 err_count  output  8  saturating count of delivered results with out_err=1.

Function
REQ-014 Bit placement SHALL be as follows; unlisted out_field bits come from in_base. I: [24:13]=imm[11:0]. S: [24:18]=imm[11:5], [4:0]=imm[4:0]. B: [24]=imm[12], [23:18]=imm[10:5], [4:1]=imm[4:1], [0]=imm[11]. J: [24]=imm[20], [23:14]=imm[10:1], [13]=imm[11], [12:5]=imm[19:12].
REQ-015 out_err SHALL be set when: I/S, imm[31:11] not all equal; B, imm[31:12] not all equal or imm[0]=1; J, imm[31:20] not all equal or imm[0]=1.
REQ-016 out_field SHALL be packed per REQ-014 even when out_err=1 (truncated bits are dropped).
REQ-017 Two-stage pipeline: stage 1 registers the request and computes the packed field and error, stage 2 is the output register.
REQ-018 A request SHALL transfer on a rising edge with in_valid and in_ready both high; a result SHALL transfer on a rising edge with out_valid and out_ready both high.
REQ-019 Stage 2 SHALL load from stage 1 when stage 2 is empty or out_ready=1.
REQ-020 in_ready SHALL equal (stage 1 empty) OR (stage 2 empty) OR out_ready, combinationally.
REQ-021 Latency SHALL be 2 edges: request accepted at edge k, out_valid high after edge k+1 when there is no backpressure.
REQ-022 Throughput SHALL be one result per cycle while out_ready=1.
REQ-023 Results SHALL be delivered in acceptance order; none dropped or duplicated under any out_ready pattern.
REQ-024 out_valid/out_field/out_err SHALL hold stable while out_valid=1 and out_ready=0.
REQ-025 err_count SHALL increment by 1 on each result transfer with out_err=1 and saturate at 255.
REQ-026 err_clr=1 SHALL set err_count to 0 at the next edge, and SHALL take priority over a simultaneous increment.
REQ-027 Encoding SHALL round-trip: extend(out_field, in_src) equals in_imm whenever out_err=0.

Reset
REQ-028 rst_n low SHALL immediately force out_valid=0, out_field=0, out_err=0, err_count=0, and both stages to empty; in_ready SHALL read 1 during reset.
REQ-029 Requests in flight at reset SHALL be discarded, and the first request after rst_n rises SHALL follow REQ-021.

Verification
REQ-030 I, in_imm=32'hFFFFF800, in_base=0 -> out_field=25'h1000000, out_err=0, 2 edges after acceptance.
REQ-031 B, in_imm=32'h00000FFE, in_base=0 -> out_field=25'h0FC001F, out_err=0; extend returns 32'h00000FFE.
REQ-032 J, in_imm=32'h00000003, in_base=0 -> out_field=25'h0004000, out_err=1, err_count=1; I with in_imm=32'h00000800 -> out_err=1, err_count=2.
REQ-033 out_ready=0, three back-to-back requests -> two accepted, in_ready=0 on the third; after out_ready=1, results emerge in order, one per cycle.
REQ-034 Drive 256 erroring results, then err_clr together with an erroring transfer -> count stays at 255, then reads 0.
REQ-035 Assert rst_n low with both stages full -> out_valid=0 and err_count=0 immediately, and no stale result appears after release.
